rca_seq_ctrl: RTL and testbench
===============================

# rca_seq_ctrl

Sequencer that performs a WIDTH-bit add with carry by time-multiplexing one existing 2-bit `fulladder2` slice over WIDTH/2 cycles. Operands enter and the result leaves over valid/ready handshakes. The block sits between a requester (board-level switch logic or a test driver) and a consumer (LED or register logic), trading latency for adder area.

## Interface
- `WIDTH`, default 32: operand width.
  - Must be even and at least 2.
  - Step count is `STEPS = WIDTH/2`.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  requester has an operand set on `a`/`b`/`cin`.
- `in_ready`  output  1  block can accept an operand set.
- `a`  input  WIDTH  operand A, unsigned or two's complement.
- `b`  input  WIDTH  operand B.
- `cin`  input  1  carry-in to bit 0.
- `out_valid`  output  1  `sum`/`cout`/`ovf` hold a completed result.
- `out_ready`  input  1  consumer accepts the result.
- `sum`  output  WIDTH  `(a + b + cin) mod 2^WIDTH`.
- `cout`  output  1  carry out of bit WIDTH-1.
- `ovf`  output  1  signed overflow: `a`[MSB]==`b`[MSB] and `sum`[MSB]!=`a`[MSB].

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`&&`in_ready`: capture `a`, `b` into shift registers and `cin` into the carry register; record the operand MSBs; clear the step counter; go to RUN.
- RUN
  - `in_ready`=0, `out_valid`=0.
  - Each cycle the slice adds `a_sh[1:0]`, `b_sh[1:0]` and the carry register.
  - `a_sh`/`b_sh` shift right by 2.
  - Slice `s` shifts into `sum_sh` from the top (`sum_sh <= {s, sum_sh[WIDTH-1:2]}`).
  - Slice `cout` loads the carry register.
  - The counter increments. When counter == STEPS-1, go to DONE after this step.
- DONE
  - `out_valid`=1.
  - `sum`=`sum_sh`, `cout`=carry register, `ovf` computed from the stored MSBs and `sum_sh`[WIDTH-1].
  - Outputs hold stable while `out_ready`=0.
  - On `out_ready`: go to IDLE.
- `in_ready` is high only in IDLE. An `in_valid` in RUN or DONE is ignored, and the requester must hold it.
- Changes to `a`/`b`/`cin` after capture have no effect on the operation in flight.
- `sum`, `cout` and `ovf` read 0 whenever `out_valid`=0.

## Timing
- Reset: state IDLE, counter 0, all shift and carry registers 0.
  - Output values under reset: `in_ready`=1 (the first cycle after reset deasserts), `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
- Latency: operands accepted at edge N give `out_valid` high in the cycle after edge N+STEPS (16 slice cycles for WIDTH=32).
- Throughput: one operation per STEPS+2 cycles minimum (accept, STEPS steps, handoff).
- `rst` asserted in any state, including mid-RUN or in DONE with a pending result: the operation is discarded and the block is in IDLE with reset values on the next cycle. No partial result is ever presented.
- Simultaneous `rst` and a handshake: `rst` wins and the handshake does not take effect.
- Counter wrap is impossible: the counter is cleared on capture and bounded by STEPS-1.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Structure
- Package `rca_seq_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} rca_seq_state_t`.
  - `localparam int SLICE_W = 2`.
- Sub-module: one instance of the existing `fulladder2`, unmodified. No other adder logic (no `+` operator on operands) in this block.
- Counter width: `$clog2(STEPS)` with a minimum of 1.

## Test plan
All scenarios use WIDTH=32.
- `a`=3, `b`=5, `cin`=0 -> after 16 RUN cycles, `out_valid`=1, `sum`=8, `cout`=0, `ovf`=0.
- `a`=0xFFFFFFFF, `b`=1, `cin`=0 -> `sum`=0, `cout`=1, `ovf`=0.
- `a`=0x7FFFFFFF, `b`=1 -> `sum`=0x80000000, `cout`=0, `ovf`=1.
- `a`=0, `b`=0, `cin`=1 -> `sum`=1. Hold `out_ready`=0 for 5 cycles in DONE -> `sum` stays 1 and `in_ready` stays 0. Pulse `out_ready` -> `in_ready`=1 next cycle.
- Start `a`=0x12345678, `b`=0x11111111 and assert `rst` at RUN step 7 -> next cycle IDLE, `out_valid`=0, `sum`=0. A new add of 0x1+0x2 then yields 3 with unchanged latency.
- Random back-to-back: 1000 operand sets with random `in_valid`/`out_ready` stalls -> every result matches a 33-bit reference model, and no result is lost or duplicated.

Source files
------------

// File: rtl/rca_seq_pkg.sv
// rca_seq_pkg: shared types and constants for the sequential ripple-carry adder
package rca_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} rca_seq_state_t;
  localparam int SLICE_W = 2;
endpackage

// File: rtl/fulladder2.sv
// fulladder2: 2-bit ripple full adder slice built from two chained full adders
module fulladder2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);
  logic c1;
  assign s[0] = a[0] ^ b[0] ^ cin;
  assign c1   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
  assign s[1] = a[1] ^ b[1] ^ c1;
  assign cout = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
endmodule

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: WIDTH-bit add with carry done 2 bits per cycle on one fulladder2 slice
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STEPS = WIDTH / SLICE_W;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  rca_seq_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic carry, a_msb, b_msb, last;
  logic [SLICE_W-1:0] fa_s;
  logic fa_co;
  assign last = cnt == CW'(STEPS - 1);
  fulladder2 u_fa (
    .a   (a_sh[SLICE_W-1:0]),
    .b   (b_sh[SLICE_W-1:0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_co)
  );
  // state register
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : nxt;
  end
  // next state: accept in IDLE, finish after the last slice step, hand off in DONE
  always_comb begin
    nxt = (state == IDLE) ? (in_valid ? RUN : IDLE) :
          (state == RUN)  ? (last ? DONE : RUN) :
          (state == DONE) ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // datapath: capture operands, then shift one slice per cycle; sum fills from the top
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE && in_valid) begin
      a_sh   <= a;
      b_sh   <= b;
      carry  <= cin;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> SLICE_W;
      b_sh   <= b_sh >> SLICE_W;
      sum_sh <= (sum_sh >> SLICE_W) | (WIDTH'(fa_s) << (WIDTH - SLICE_W));
      carry  <= fa_co;
      cnt    <= last ? cnt : cnt + 1'b1;
    end
  end
  // outputs are decoded from state only, and results are masked unless presented
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    sum       = out_valid ? sum_sh : '0;
    cout      = out_valid & carry;
    ovf       = out_valid & (a_msb == b_msb) & (sum_sh[WIDTH-1] != a_msb);
  end
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb_rca_seq_ctrl: scoreboard bench for the sequential adder
module tb_rca_seq_ctrl;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;
  int tests = 0, fails = 0;
  logic [W+1:0] sb[$];
  logic [W+1:0] last_res;

  rca_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    logic v;
    t = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {t[W], v, t[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input int hold);
    int lat;
    logic [W+1:0] e;
    e = '0;
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    check("op_rdy", 64'(in_ready), 64'd1);
    sb.push_back(ref_model(ia, ib, ic));
    step();
    in_valid = 1'b0;
    a = ~ia; b = ~ib; cin = ~ic;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check("op_lat", 64'(lat), 64'd16);
    if (sb.size() == 0) check("op_sb_empty", 64'd1, 64'd0);
    else e = sb.pop_front();
    last_res = {cout, ovf, sum};
    check("op_res", 64'(last_res), 64'(e));
    repeat (hold) begin
      step();
      check("hold_res", 64'({cout, ovf, sum}), 64'(e));
      check("hold_hs", 64'({in_ready, out_valid}), 64'b01);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("op_release", 64'({in_ready, out_valid, cout, ovf, sum}), {28'd0, 2'b10, 34'd0});
  endtask

  initial begin
    int sent, got, cyc;
    bit acc;
    step();
    step();
    check("rst_out", 64'({in_ready, out_valid, cout, ovf, sum}), {28'd0, 2'b10, 34'd0});
    rst = 1'b0;
    run_op(32'd3, 32'd5, 1'b0, 0);
    check("add_3_5", 64'(last_res), 64'({2'b00, 32'd8}));
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    check("add_wrap", 64'(last_res), 64'({2'b10, 32'd0}));
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 0);
    check("add_ovf", 64'(last_res), 64'({2'b01, 32'h8000_0000}));
    run_op(32'd0, 32'd0, 1'b1, 5);
    check("add_cin", 64'(last_res), 64'({2'b00, 32'd1}));
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_run", 64'({in_ready, out_valid, cout, ovf, sum}), {28'd0, 2'b10, 34'd0});
    run_op(32'd1, 32'd2, 1'b0, 0);
    check("add_after_rst", 64'(last_res), 64'({2'b00, 32'd3}));
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (16) step();
    check("done_pend", 64'(out_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_done", 64'({in_ready, out_valid, cout, ovf, sum}), {28'd0, 2'b10, 34'd0});
    rst = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("rst_hs", 64'({in_ready, out_valid}), 64'b10);
    sent = 0; got = 0; cyc = 0;
    while ((sent < 1000 || got < sent) && cyc < 80000) begin
      acc = 1'b0;
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      end
      out_ready = $urandom_range(0, 2) != 0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("rand_dup", 64'd1, 64'd0);
        else check("rand_res", 64'({cout, ovf, sum}), 64'(sb.pop_front()));
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_model(a, b, cin));
        sent++;
        acc = 1'b1;
      end
      step();
      cyc++;
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    check("rand_count", 64'(got), 64'd1000);
    check("rand_left", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
